// File: rtl/data_mem_io_pkg.sv
// data_mem_io_pkg: address map, UART FSM states and status bit positions
// shared by the data-side memory subsystem.
package data_mem_io_pkg;
    localparam logic [31:0] IO_BASE        = 32'h8000_0000;
    localparam logic [31:0] LED_ADDR       = IO_BASE;
    localparam logic [31:0] TIMER_ADDR     = IO_BASE + 32'h4;
    localparam logic [31:0] UART_TX_ADDR   = IO_BASE + 32'h8;
    localparam logic [31:0] UART_STAT_ADDR = IO_BASE + 32'hC;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;
endpackage

// File: rtl/data_mem_io_if.sv
// data_mem_io_if: Memory-stage data bus between the core (master) and the
// memory subsystem (slave).
interface data_mem_io_if;
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, we, wd, input rd);
    modport slave  (input a, we, wd, output rd);
endinterface

// File: rtl/data_mem_io_uart_tx_fifo.sv
// uart_tx_fifo: 4-entry byte FIFO with sticky overflow feeding an 8N1
// transmitter; STOP pops the next byte directly for back-to-back frames.
module uart_tx_fifo
    import data_mem_io_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic [2:0] count
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    uart_state_t   state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    fifo_q [4];
    logic [1:0]    wp_q, rp_q;
    logic [2:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pop, push_ok, div_end;

    assign empty    = cnt_q == 3'd0;
    assign full     = cnt_q == 3'd4;
    assign busy     = state_q != IDLE;
    assign overflow = ovf_q;
    assign count    = cnt_q;
    assign div_end  = div_q == DW'(CLK_DIV - 1);
    // A push is judged against the pre-pop count, so a full FIFO drops it.
    assign push_ok  = push && !full;
    assign cnt_d    = cnt_q + {2'b0, push_ok} - {2'b0, pop};
    assign ovf_d    = (push && full) || (ovf_q && !clr_ovf);
    assign tx       = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;

    always_comb begin
        state_d = state_q;
        div_d   = div_end ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_q[rp_q];
                    state_d = START;
                end
            end
            START: if (div_end) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (div_end) begin
                sh_d    = sh_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (div_end) begin
                pop     = !empty;
                sh_d    = empty ? sh_q : fifo_q[rp_q];
                state_d = empty ? IDLE : START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            wp_q    <= 2'd0;
            rp_q    <= 2'd0;
            cnt_q   <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            wp_q    <= wp_q + {1'b0, push_ok};
            rp_q    <= rp_q + {1'b0, pop};
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wp_q] <= din;
    end
endmodule

// File: rtl/data_mem_io.sv
// data_mem_io: data-side memory subsystem; decodes the Memory-stage bus to
// word RAM, LED register, free-running timer and the UART transmitter.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int CLK_DIV   = 16
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_io_if.slave  bus,
    output logic [7:0]    led,
    output logic          uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] timer_q, timer_d, wa, stat;
    logic [7:0]  led_q, led_d;
    logic [AW-1:0] idx;
    logic        sel_ram, sel_led, sel_timer, sel_tx, sel_stat;
    logic        full, empty, busy, ovf;
    logic [2:0]  count;

    assign wa        = {bus.a[31:2], 2'b00};
    assign idx       = bus.a[AW+1:2];
    assign sel_ram   = !bus.a[31];
    assign sel_led   = wa == LED_ADDR;
    assign sel_timer = wa == TIMER_ADDR;
    assign sel_tx    = wa == UART_TX_ADDR;
    assign sel_stat  = wa == UART_STAT_ADDR;
    assign led_d     = bus.we && sel_led ? bus.wd[7:0] : led_q;
    assign timer_d   = bus.we && sel_timer ? bus.wd : timer_q + 32'd1;
    assign led       = led_q;

    always_comb begin
        stat              = 32'd0;
        stat[STAT_FULL]   = full;
        stat[STAT_EMPTY]  = empty;
        stat[STAT_BUSY]   = busy;
        stat[STAT_OVF]    = ovf;
        stat[STAT_CNT+:3] = count;
        bus.rd = sel_ram   ? mem[idx] :
                 sel_led   ? {24'd0, led_q} :
                 sel_timer ? timer_q :
                 sel_stat  ? stat : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= 8'd0;
            timer_q <= 32'd0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.we && sel_ram) mem[idx] <= bus.wd;
    end

    uart_tx_fifo #(.CLK_DIV(CLK_DIV)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.we && sel_tx),
        .din      (bus.wd[7:0]),
        .clr_ovf  (bus.we && sel_stat && bus.wd[STAT_OVF]),
        .tx       (uart_tx),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (ovf),
        .count    (count)
    );
endmodule
